lfsr_gen: RTL and testbench
===========================

Name: lfsr_gen

Overview:
- Parametrised pseudo-random sequence generator; next generation of the team's 8-bit fixed-tap LFSR.
- Adds configurable width, runtime tap mask, Fibonacci or Galois mode, and free-run or single-step advance.
- Adds synchronous seed load, all-zero lockup recovery and hardware period measurement.
- Sits behind the tile I/O wrapper; drives pattern outputs and the status bits read back by test firmware.

Parameters:
- WIDTH, 8, state/output width; legal 3..32.
- SEED, 1 (WIDTH bits), reset seed and lockup recovery value; must be nonzero.
- TAPS, 8'hB8 (zero-extended to WIDTH), reset tap mask; bit i selects state[i].

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  global enable; when low, all state holds except load
- run  in  1  1 = advance every enabled cycle
- step  in  1  single-cycle advance request, used when run=0
- mode  in  1  0 = Fibonacci, 1 = Galois; sampled each advance
- load  in  1  load seed_in this cycle
- seed_in  in  WIDTH  value for load
- taps_we  in  1  write taps_in to the tap register
- taps_in  in  WIDTH  new tap mask
- q  out  WIDTH  registered output; the state before the most recent advance
- wrap  out  1  one-cycle pulse when the sequence returns to the reference seed
- period  out  WIDTH  advances in the last completed cycle
- lockup  out  1  sticky flag: an all-zero state was recovered
- no_wrap  out  1  sticky flag: counter saturated without a wrap

Behaviour:
- Reset (async, rst_n=0):
  - state=SEED, q=SEED, taps=TAPS, ref_seed=SEED.
  - cnt=0, period=0, wrap=0, lockup=0, no_wrap=0.
- adv = ena & (run | step) & ~load. The step input is level-sampled; each cycle it is high counts as one advance.
- Fibonacci next state:
  - fb = XOR-reduce(state & taps).
  - next = {state[WIDTH-2:0], fb}.
- Galois next state: next = {state[WIDTH-2:0], 1'b0} XOR (state[WIDTH-1] ? taps : 0).
- On adv with state != 0:
  - state <= next; q <= state (one advance of latency; the first q after reset or load is the seed).
  - cnt <= cnt+1.
- Wrap detection (on adv):
  - If next == ref_seed: wrap=1 for exactly one cycle, period <= cnt+1, cnt <= 0.
  - Otherwise wrap=0.
- Counter saturation: if cnt reaches 2^WIDTH-1 without a wrap, cnt holds and no_wrap is set. no_wrap is cleared by load or taps_we.
- Lockup recovery: on adv with state == 0:
  - state <= SEED, q <= 0, ref_seed <= SEED, cnt <= 0, lockup <= 1.
  - wrap stays 0.
- Load (when ena=1 or ena=0; load has priority over adv):
  - state <= seed_in, q <= seed_in, ref_seed <= seed_in.
  - cnt <= 0, wrap <= 0; lockup and no_wrap cleared; period unchanged.
  - A zero seed is accepted and is recovered on the next adv.
- taps_we:
  - taps <= taps_in; cnt <= 0; no_wrap cleared.
  - The state is not altered. A same-cycle adv uses the old taps.
  - taps_we together with load: both take effect.
- mode change mid-run takes effect on the next adv. cnt is not cleared, so the first period reported afterwards is undefined.
- ena=0: state, q, cnt, taps and flags all hold; load still acts; wrap is forced to 0.
- Reset mid-run asynchronously returns all registers to their reset values. The first enabled cycle after reset reproduces the power-up sequence exactly.
- All arithmetic is unsigned WIDTH bits; no overflow past the saturation rule.

Test Plan:
- WIDTH=8, Fibonacci, default TAPS/SEED, run=1, ena=1 after reset -> q = 01,01,02,04,08,11,23 on consecutive cycles.
- Same config, run for 255 advances -> wrap pulses exactly once on advance 255, period=8'd255, no_wrap=0; a second wrap follows 255 advances later.
- mode=1, taps_we with 8'h1D, load 8'h01 -> state walks 01,02,...,80,1D; wrap after 255 advances, period=255.
- run=0, step high for 3 separate single cycles with idle gaps, ena toggled low between them -> exactly 3 advances, q=04 afterwards, no change while ena=0.
- load seed_in=0, then one adv -> q=00, state=SEED (01), lockup=1; a later load of 8'h5A -> lockup=0, q=5A next cycle.
- Non-maximal taps 8'h80 with seed 8'h02 run past 255 advances -> no_wrap=1, wrap never asserts. rst_n pulsed low mid-run -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - parametrised Fibonacci/Galois LFSR with seed load, lockup recovery and period measurement
module lfsr_gen #(
   parameter int unsigned      WIDTH = 8,
   parameter logic [WIDTH-1:0] SEED  = 'd1,
   parameter logic [WIDTH-1:0] TAPS  = 'hB8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             run,
   input  logic             step,
   input  logic             mode,
   input  logic             load,
   input  logic [WIDTH-1:0] seed_in,
   input  logic             taps_we,
   input  logic [WIDTH-1:0] taps_in,
   output logic [WIDTH-1:0] q,
   output logic             wrap,
   output logic [WIDTH-1:0] period,
   output logic             lockup,
   output logic             no_wrap
);
   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] taps_q, taps_d;
   logic [WIDTH-1:0] ref_q, ref_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic             wrap_q, wrap_d;
   logic             lockup_q, lockup_d;
   logic             no_wrap_q, no_wrap_d;

   logic             adv;
   logic             fb;
   logic [WIDTH-1:0] fib_next, gal_next, next_state;

   assign adv        = ena & (run | step) & ~load;
   assign fb         = ^(state_q & taps_q);
   assign fib_next   = {state_q[WIDTH-2:0], fb};
   assign gal_next   = {state_q[WIDTH-2:0], 1'b0} ^ (state_q[WIDTH-1] ? taps_q : '0);
   assign next_state = mode ? gal_next : fib_next;

   always_comb begin
      state_d   = state_q;
      q_d       = q_q;
      taps_d    = taps_q;
      ref_d     = ref_q;
      cnt_d     = cnt_q;
      period_d  = period_q;
      wrap_d    = 1'b0;
      lockup_d  = lockup_q;
      no_wrap_d = no_wrap_q;

      if (load) begin
         state_d   = seed_in;
         q_d       = seed_in;
         ref_d     = seed_in;
         cnt_d     = '0;
         lockup_d  = 1'b0;
         no_wrap_d = 1'b0;
      end else if (adv) begin
         if (state_q == '0) begin
            // All-zero state would lock the register forever; restart from SEED.
            state_d  = SEED;
            q_d      = '0;
            ref_d    = SEED;
            cnt_d    = '0;
            lockup_d = 1'b1;
         end else begin
            state_d = next_state;
            q_d     = state_q;
            if (next_state == ref_q) begin
               wrap_d   = 1'b1;
               period_d = cnt_q + 1'b1;
               cnt_d    = '0;
            end else begin
               cnt_d     = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
               no_wrap_d = no_wrap_q | (cnt_d == CNT_MAX);
            end
         end
      end

      // Tap write lands after the advance so a same-cycle advance uses the old taps.
      if (ena && taps_we) begin
         taps_d    = taps_in;
         cnt_d     = '0;
         no_wrap_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= SEED;
         q_q       <= SEED;
         taps_q    <= TAPS;
         ref_q     <= SEED;
         cnt_q     <= '0;
         period_q  <= '0;
         wrap_q    <= 1'b0;
         lockup_q  <= 1'b0;
         no_wrap_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         q_q       <= q_d;
         taps_q    <= taps_d;
         ref_q     <= ref_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         wrap_q    <= wrap_d;
         lockup_q  <= lockup_d;
         no_wrap_q <= no_wrap_d;
      end
   end

   assign q       = q_q;
   assign wrap    = wrap_q;
   assign period  = period_q;
   assign lockup  = lockup_q;
   assign no_wrap = no_wrap_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - scoreboard testbench for lfsr_gen at WIDTH=8
module tb_lfsr_gen;
   logic       clk;
   logic       rst_n;
   logic       ena, run, step, mode, load, taps_we;
   logic [7:0] seed_in, taps_in;
   logic [7:0] q, period;
   logic       wrap, lockup, no_wrap;
   logic [18:0] obs;

   int errors = 0;
   int checks = 0;

   logic [7:0] m_state, m_q, m_taps, m_ref, m_cnt, m_period;
   logic       m_wrap, m_lock, m_nw;
   logic [18:0] sb[$];

   lfsr_gen #(.WIDTH(8), .SEED(8'h01), .TAPS(8'hB8)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .run(run), .step(step), .mode(mode),
      .load(load), .seed_in(seed_in), .taps_we(taps_we), .taps_in(taps_in),
      .q(q), .wrap(wrap), .period(period), .lockup(lockup), .no_wrap(no_wrap)
   );

   assign obs = {q, wrap, period, lockup, no_wrap};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_state = 8'h01; m_q = 8'h01; m_taps = 8'hB8; m_ref = 8'h01;
      m_cnt = 8'h00; m_period = 8'h00; m_wrap = 1'b0; m_lock = 1'b0; m_nw = 1'b0;
   endtask

   task automatic model_step();
      logic       a;
      logic [7:0] nx;
      a = ena & (run | step) & ~load;
      m_wrap = 1'b0;
      if (load) begin
         m_state = seed_in; m_q = seed_in; m_ref = seed_in;
         m_cnt = 8'h00; m_lock = 1'b0; m_nw = 1'b0;
      end else if (a) begin
         if (m_state == 8'h00) begin
            m_state = 8'h01; m_q = 8'h00; m_ref = 8'h01; m_cnt = 8'h00; m_lock = 1'b1;
         end else begin
            if (mode) begin
               nx = m_state << 1;
               if (m_state[7]) nx = nx ^ m_taps;
            end else begin
               nx = {m_state[6:0], ^(m_state & m_taps)};
            end
            m_q = m_state;
            m_state = nx;
            if (nx == m_ref) begin
               m_wrap = 1'b1;
               m_period = 8'(m_cnt + 8'd1);
               m_cnt = 8'h00;
            end else if (m_cnt != 8'hFF) begin
               m_cnt = 8'(m_cnt + 8'd1);
               if (m_cnt == 8'hFF) m_nw = 1'b1;
            end
         end
      end
      if (ena && taps_we) begin
         m_taps = taps_in; m_cnt = 8'h00; m_nw = 1'b0;
      end
      sb.push_back({m_q, m_wrap, m_period, m_lock, m_nw});
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ena = 1'b1; run = 1'b0; step = 1'b0; mode = 1'b0; load = 1'b0; taps_we = 1'b0;
      seed_in = 8'h00; taps_in = 8'h00;
      model_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (obs !== {8'h01, 1'b0, 8'h00, 1'b0, 1'b0}) begin
         errors++; $display("FAIL reset got=%h exp=%h", obs, {8'h01, 1'b0, 8'h00, 1'b0, 1'b0});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_fib_sequence(input string tag);
      logic [7:0] seq [6];
      logic [18:0] e;
      seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
      run = 1'b1; mode = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin
            errors++; $display("FAIL %s_model adv=%0d got=%h exp=%h", tag, i + 1, obs, e);
         end
         checks++;
         if (q !== seq[i]) begin
            errors++; $display("FAIL %s_q adv=%0d got=%h exp=%h", tag, i + 1, q, seq[i]);
         end
      end
   endtask

   task automatic test_fib_wrap();
      int wraps[$];
      int bad = 0;
      logic [18:0] e;
      for (int n = 7; n <= 520; n++) begin
         tick();
         e = sb.pop_front();
         if (obs !== e) bad++;
         if (wrap) wraps.push_back(n);
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL fib_wrap_model mismatching_cycles=%0d exp=0", bad);
      end
      checks++;
      if (wraps.size() != 2) begin
         errors++; $display("FAIL fib_wrap_count got=%0d exp=2", wraps.size());
      end else begin
         checks++;
         if (wraps[0] != 255 || wraps[1] != 510) begin
            errors++; $display("FAIL fib_wrap_pos got=%0d,%0d exp=255,510", wraps[0], wraps[1]);
         end
      end
      checks++;
      if (period !== 8'd255 || no_wrap !== 1'b0) begin
         errors++; $display("FAIL fib_period got=%0d/%b exp=255/0", period, no_wrap);
      end
   endtask

   task automatic test_galois();
      logic [7:0] walk [9];
      logic [18:0] e;
      int wraps[$];
      int bad = 0;
      walk = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D};
      run = 1'b0; mode = 1'b1; taps_we = 1'b1; taps_in = 8'h1D;
      tick(); e = sb.pop_front(); if (obs !== e) bad++;
      taps_we = 1'b0; load = 1'b1; seed_in = 8'h01;
      tick(); e = sb.pop_front(); if (obs !== e) bad++;
      load = 1'b0; run = 1'b1;
      for (int k = 1; k <= 255; k++) begin
         tick();
         e = sb.pop_front();
         if (obs !== e) bad++;
         if (wrap) wraps.push_back(k);
         if (k <= 9) begin
            checks++;
            if (q !== walk[k - 1]) begin
               errors++; $display("FAIL galois_walk adv=%0d got=%h exp=%h", k, q, walk[k - 1]);
            end
         end
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL galois_model mismatching_cycles=%0d exp=0", bad);
      end
      checks++;
      if (wraps.size() != 1 || period !== 8'd255) begin
         errors++; $display("FAIL galois_wrap count=%0d period=%0d exp=1/255", wraps.size(), period);
      end else begin
         checks++;
         if (wraps[0] != 255) begin
            errors++; $display("FAIL galois_wrap_pos got=%0d exp=255", wraps[0]);
         end
      end
   endtask

   task automatic test_step_ena();
      logic [1:0] pat [11];
      logic [18:0] e;
      pat = '{2'b11, 2'b10, 2'b01, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
      run = 1'b0; mode = 1'b0; load = 1'b1; seed_in = 8'h01; taps_we = 1'b1; taps_in = 8'hB8;
      tick(); e = sb.pop_front();
      checks++;
      if (obs !== e) begin
         errors++; $display("FAIL step_load got=%h exp=%h", obs, e);
      end
      load = 1'b0; taps_we = 1'b0;
      for (int i = 0; i < 11; i++) begin
         ena = pat[i][1]; step = pat[i][0];
         tick();
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin
            errors++; $display("FAIL step_ena cyc=%0d got=%h exp=%h", i, obs, e);
         end
      end
      ena = 1'b1; step = 1'b0;
      checks++;
      if (q !== 8'h04) begin
         errors++; $display("FAIL step_final_q got=%h exp=04", q);
      end
   endtask

   task automatic test_lockup();
      logic [18:0] e;
      run = 1'b1; mode = 1'b0; load = 1'b1; seed_in = 8'h00;
      tick(); e = sb.pop_front();
      checks++;
      if (obs !== e) begin
         errors++; $display("FAIL lock_load0 got=%h exp=%h", obs, e);
      end
      load = 1'b0;
      tick(); e = sb.pop_front();
      checks++;
      if (q !== 8'h00 || lockup !== 1'b1 || wrap !== 1'b0 || obs !== e) begin
         errors++; $display("FAIL lock_recover got=%h exp=%h", obs, e);
      end
      tick(); e = sb.pop_front();
      checks++;
      if (q !== 8'h01 || obs !== e) begin
         errors++; $display("FAIL lock_seed got=%h exp=%h", obs, e);
      end
      load = 1'b1; seed_in = 8'h5A;
      tick(); e = sb.pop_front();
      checks++;
      if (q !== 8'h5A || lockup !== 1'b0 || obs !== e) begin
         errors++; $display("FAIL lock_reload got=%h exp=%h", obs, e);
      end
      load = 1'b0;
   endtask

   task automatic test_no_wrap();
      logic [18:0] e;
      int nw_wraps = 0;
      int bad = 0;
      run = 1'b0; mode = 1'b1; load = 1'b1; seed_in = 8'h02; taps_we = 1'b1; taps_in = 8'h80;
      tick(); e = sb.pop_front(); if (obs !== e) bad++;
      load = 1'b0; taps_we = 1'b0; run = 1'b1;
      for (int i = 0; i < 300; i++) begin
         tick();
         e = sb.pop_front();
         if (obs !== e) bad++;
         if (wrap) nw_wraps++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL nowrap_model mismatching_cycles=%0d exp=0", bad);
      end
      checks++;
      if (no_wrap !== 1'b1 || nw_wraps != 0) begin
         errors++; $display("FAIL nowrap_flag got=%b wraps=%0d exp=1/0", no_wrap, nw_wraps);
      end
   endtask

   task automatic test_async_reset();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== {8'h01, 1'b0, 8'h00, 1'b0, 1'b0}) begin
         errors++; $display("FAIL async_reset got=%h exp=%h", obs, {8'h01, 1'b0, 8'h00, 1'b0, 1'b0});
      end
      sb.delete();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_fib_sequence("post_reset");
   endtask

   initial begin
      test_reset();
      test_fib_sequence("fib_seq");
      test_fib_wrap();
      test_galois();
      test_step_ena();
      test_lockup();
      test_no_wrap();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
